// File: rtl/seq_divider_if.sv
// seq_divider_if: set/ready handshake bundle between the lab controller and the divider
interface seq_divider_if #(parameter int N = 4);
  logic         set;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         div_by_zero;
  modport master (output set, a, b, input ready, q, r, div_by_zero);
  modport slave (input set, a, b, output ready, q, r, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock, MSB first
module seq_divider #(parameter int N = 4) (
  input logic         clk,
  input logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t        state;
  logic [N-1:0]  dq;
  logic [N-1:0]  dv;
  logic [N-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          zero;
  logic [N:0]    t;
  logic [N:0]    diff;
  logic          ge;
  // trial remainder: shift the next dividend bit into the partial remainder and try the subtract
  always_comb begin
    t    = {rem, dq[N-1]};
    diff = t - {1'b0, dv};
    ge   = t >= {1'b0, dv};
  end
  // control FSM and datapath; dq holds the latched dividend, which is also the zero-divide remainder
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dq              <= '0;
      dv              <= '0;
      rem             <= '0;
      cnt             <= '0;
      zero            <= 1'b0;
      bus.ready       <= 1'b0;
      bus.q           <= '0;
      bus.r           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      case (state)
        IDLE: if (bus.set) begin
          dq    <= bus.a;
          dv    <= bus.b;
          rem   <= '0;
          cnt   <= CW'(N - 1);
          zero  <= bus.b == '0;
          state <= (bus.b == '0) ? DONE : RUN;
        end
        RUN: begin
          dq    <= {dq[N-2:0], ge};
          rem   <= ge ? diff[N-1:0] : t[N-1:0];
          cnt   <= cnt - 1'b1;
          state <= (cnt == '0) ? DONE : RUN;
        end
        DONE: begin
          bus.q           <= zero ? '1 : dq;
          bus.r           <= zero ? dq : rem;
          bus.div_by_zero <= zero;
          bus.ready       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for the divider at N=4 and N=8
module tb_seq_divider;
  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp4[$];
  exp_t exp8[$];

  seq_divider_if #(.N(4)) if4 ();
  seq_divider_if #(.N(8)) if8 ();

  seq_divider #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_divider #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;

  // count rising edges so latency can be checked against the accept edge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int a, int b, int n, int e);
    exp_t x;
    int m;
    m     = (1 << n) - 1;
    x.a   = a;
    x.b   = b;
    x.dbz = (b == 0) ? 1 : 0;
    x.q   = (b == 0) ? m : a / b;
    x.r   = (b == 0) ? a : a % b;
    x.cyc = e + ((b == 0) ? 1 : n + 1);
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_res(string tag, exp_t e, int q, int r, int dbz);
    chk($sformatf("%s_q_%0d/%0d", tag, e.a, e.b), q, e.q);
    chk($sformatf("%s_r_%0d/%0d", tag, e.a, e.b), r, e.r);
    chk($sformatf("%s_dbz_%0d/%0d", tag, e.a, e.b), dbz, e.dbz);
    chk($sformatf("%s_latency_%0d/%0d", tag, e.a, e.b), cyc, e.cyc);
    if (e.b != 0)
      chk($sformatf("%s_invariant_%0d/%0d", tag, e.a, e.b), (q * e.b + r == e.a && r < e.b) ? 1 : 0, 1);
  endtask

  // N=4 monitor: every ready pulse must match the oldest outstanding request
  always @(negedge clk) if (rst_n && if4.ready) begin
    if (exp4.size() == 0) chk("n4_unexpected_ready", 1, 0);
    else begin
      exp_t e;
      e = exp4.pop_front();
      check_res("n4", e, int'(if4.q), int'(if4.r), int'(if4.div_by_zero));
    end
  end

  // N=8 monitor
  always @(negedge clk) if (rst_n && if8.ready) begin
    if (exp8.size() == 0) chk("n8_unexpected_ready", 1, 0);
    else begin
      exp_t e;
      e = exp8.pop_front();
      check_res("n8", e, int'(if8.q), int'(if8.r), int'(if8.div_by_zero));
    end
  end

  task automatic wait_ready4();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if4.ready && k < 40);
    if (!if4.ready) chk("n4_ready_timeout", 0, 1);
  endtask

  task automatic wait_ready8();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!if8.ready && k < 40);
    if (!if8.ready) chk("n8_ready_timeout", 0, 1);
  endtask

  task automatic op4(int a, int b);
    @(negedge clk);
    if4.set = 1'b1;
    if4.a   = a[3:0];
    if4.b   = b[3:0];
    exp4.push_back(model(a, b, 4, cyc + 1));
    @(negedge clk);
    if4.set = 1'b0;
    if4.a   = 4'($urandom);
    if4.b   = 4'($urandom);
    wait_ready4();
  endtask

  initial begin
    int e;
    if4.set = 1'b0; if4.a = '0; if4.b = '0;
    if8.set = 1'b0; if8.a = '0; if8.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(if4.ready), 0);
    chk("reset_q", int'(if4.q), 0);
    chk("reset_r", int'(if4.r), 0);
    chk("reset_dbz", int'(if4.div_by_zero), 0);
    rst_n = 1'b1;
    op4(13, 3);
    op4(7, 0);
    op4(6, 2);
    op4(15, 1);
    op4(2, 9);
    op4(0, 5);
    op4(15, 15);
    // set during RUN must be ignored
    @(negedge clk);
    if4.set = 1'b1; if4.a = 4'd9; if4.b = 4'd2;
    exp4.push_back(model(9, 2, 4, cyc + 1));
    @(negedge clk);
    if4.set = 1'b0;
    @(negedge clk);
    if4.set = 1'b1; if4.a = 4'd1; if4.b = 4'd1;
    @(negedge clk);
    if4.set = 1'b0;
    wait_ready4();
    repeat (8) @(negedge clk);
    // reset mid-RUN aborts with no ready and clears the outputs
    if4.set = 1'b1; if4.a = 4'd11; if4.b = 4'd2;
    @(negedge clk);
    if4.set = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_reset_q", int'(if4.q), 0);
    chk("midrun_reset_r", int'(if4.r), 0);
    chk("midrun_reset_ready", int'(if4.ready), 0);
    repeat (8) @(negedge clk);
    op4(10, 3);
    // N=8 back-to-back with set held high
    @(negedge clk);
    e = cyc + 1;
    if8.set = 1'b1; if8.a = 8'd255; if8.b = 8'd16;
    exp8.push_back(model(255, 16, 8, e));
    @(negedge clk);
    if8.a = 8'd200; if8.b = 8'd7;
    exp8.push_back(model(200, 7, 8, e + 10));
    repeat (10) @(negedge clk);
    if8.set = 1'b0;
    wait_ready8();
    // exhaustive N=4 sweep with random idle gaps, then random pairs
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        op4(a, b);
      end
    for (int i = 0; i < 64; i++) op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    repeat (12) @(negedge clk);
    chk("n4_queue_drained", exp4.size(), 0);
    chk("n8_queue_drained", exp8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
